// File: rtl/piezo_pkg.sv
// Shared definitions for the piezo phase-lock controller: state encoding,
// default widths and loop constants, and the increment clamp helper.
package piezo_pkg;

    localparam int INC_W      = 15;
    localparam int PH_W       = 9;
    localparam int INC_START  = 27500;
    localparam int INC_MIN    = 25000;
    localparam int INC_MAX    = 28500;
    localparam int SWEEP_STEP = 4;
    localparam int KP_SHIFT   = 3;
    localparam int LOCK_TOL   = 8;
    localparam int LOCK_CNT   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SWEEP = 2'b01,
        ST_TRACK = 2'b10,
        ST_FAULT = 2'b11
    } plc_state_t;

    // Saturate v into [lo, hi]; operands are wide enough that the sum never wraps
    function automatic int clamp_int(input int v, input int lo, input int hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/piezo_phase_lock_ctrl_phase_avg4.sv
// Four-sample phase averager used by the tracking loop when PIEZO_PLC_AVG_EN
// is defined. The three previous samples are stored; the current sample is
// added combinationally so the mean is usable on the same strobe.
`ifdef PIEZO_PLC_AVG_EN
module phase_avg4 #(
    parameter int PH_W = piezo_pkg::PH_W
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   load,
    input  logic                   shift,
    input  logic signed [PH_W-1:0] sample,
    output logic signed [PH_W-1:0] mean
);

    logic signed [PH_W-1:0] hist_reg [3];
    logic signed [PH_W+1:0] sum;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_hist
            // History slot: preloaded with the entry sample, then shifted one per strobe
            always_ff @(posedge clk) begin
                if (srst) begin
                    hist_reg[gi] <= '0;
                end else if (load) begin
                    hist_reg[gi] <= sample;
                end else if (shift) begin
                    if (gi == 0) begin
                        hist_reg[gi] <= sample;
                    end else begin
                        hist_reg[gi] <= hist_reg[(gi == 0) ? 0 : gi - 1];
                    end
                end
            end
        end
    endgenerate

    // Mean of the current sample and the three stored ones, floored
    always_comb begin
        sum  = (PH_W+2)'(sample) + (PH_W+2)'(hist_reg[0])
             + (PH_W+2)'(hist_reg[1]) + (PH_W+2)'(hist_reg[2]);
        mean = PH_W'(sum >>> 2);
    end

endmodule
`endif

// File: rtl/piezo_phase_lock_ctrl.sv
// Closed-loop VCO frequency controller for the piezo transformer drive.
// IDLE -> downward SWEEP until the phase error turns non-negative (resonance),
// then proportional TRACK with lock detection; short circuit forces FAULT.
// Optional: define PIEZO_PLC_AVG_EN to track on a 4-sample mean of the phase.
module piezo_phase_lock_ctrl #(
    parameter int INC_W      = piezo_pkg::INC_W,
    parameter int PH_W       = piezo_pkg::PH_W,
    parameter int INC_START  = piezo_pkg::INC_START,
    parameter int INC_MIN    = piezo_pkg::INC_MIN,
    parameter int INC_MAX    = piezo_pkg::INC_MAX,
    parameter int SWEEP_STEP = piezo_pkg::SWEEP_STEP,
    parameter int KP_SHIFT   = piezo_pkg::KP_SHIFT,
    parameter int LOCK_TOL   = piezo_pkg::LOCK_TOL,
    parameter int LOCK_CNT   = piezo_pkg::LOCK_CNT
) (
    input  logic             clk12d5MHz,
    input  logic             rst,
    input  logic             enable,
    input  logic [PH_W-1:0]  phase,
    input  logic             phase_vld,
    input  logic             short_fault,
    output logic [INC_W-1:0] increment,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       state_o
);
    import piezo_pkg::*;

    localparam int CNT_W = $clog2(LOCK_CNT + 1);

    plc_state_t             state_reg, state_next;
    logic [INC_W-1:0]       increment_reg, increment_next;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic                   locked_reg, locked_next;
    logic                   fault_reg;
    logic signed [PH_W-1:0] eff_phase;
    logic signed [PH_W:0]   eff_ext;
    logic signed [PH_W:0]   eff_mag;
    logic                   in_tol;
    logic                   phase_neg;
    int                     dec_i;
    int                     trk_i;

    assign phase_neg = phase[PH_W-1];

`ifdef PIEZO_PLC_AVG_EN
    logic avg_load;
    logic avg_shift;

    // History is seeded by the sample that ends the sweep, and advances on every tracked strobe
    assign avg_load  = (state_reg == ST_SWEEP) && (state_next == ST_TRACK);
    assign avg_shift = (state_reg == ST_TRACK) && (state_next == ST_TRACK) && phase_vld;

    phase_avg4 #(.PH_W(PH_W)) u_avg (
        .clk    (clk12d5MHz),
        .srst   (rst),
        .load   (avg_load),
        .shift  (avg_shift),
        .sample (signed'(phase)),
        .mean   (eff_phase)
    );
`else
    assign eff_phase = signed'(phase);
`endif

    // Magnitude is one bit wider so the most negative code is out of tolerance
    assign eff_ext = eff_phase;
    assign eff_mag = (eff_ext < 0) ? -eff_ext : eff_ext;
    assign in_tol  = int'(eff_mag) <= LOCK_TOL;

    assign dec_i = int'(increment_reg) - SWEEP_STEP;
    assign trk_i = clamp_int(int'(increment_reg) + int'(eff_phase >>> KP_SHIFT), INC_MIN, INC_MAX);

    // State register
    always_ff @(posedge clk12d5MHz) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: short circuit wins, then enable, then strobed phase
    always_comb begin
        state_next = state_reg;
        if (short_fault) begin
            state_next = ST_FAULT;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (enable) state_next = ST_SWEEP;
                end
                ST_SWEEP: begin
                    if (!enable) begin
                        state_next = ST_IDLE;
                    end else if (phase_vld) begin
                        if (!phase_neg)           state_next = ST_TRACK;
                        else if (dec_i < INC_MIN) state_next = ST_FAULT;
                    end
                end
                ST_TRACK: begin
                    if (!enable) state_next = ST_IDLE;
                end
                default: begin
                    if (!enable) state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath next values: increment, lock counter and lock flag
    always_comb begin
        increment_next = increment_reg;
        count_next     = count_reg;
        locked_next    = locked_reg;
        if (short_fault) begin
            count_next  = '0;
            locked_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    increment_next = INC_W'(INC_START);
                    count_next     = '0;
                    locked_next    = 1'b0;
                end
                ST_SWEEP: begin
                    if (!enable) begin
                        increment_next = INC_W'(INC_START);
                    end else if (phase_vld && phase_neg && dec_i >= INC_MIN) begin
                        increment_next = INC_W'(dec_i);
                    end
                end
                ST_TRACK: begin
                    if (!enable) begin
                        increment_next = INC_W'(INC_START);
                        count_next     = '0;
                        locked_next    = 1'b0;
                    end else if (phase_vld) begin
                        increment_next = INC_W'(trk_i);
                        if (in_tol) begin
                            count_next  = (count_reg == CNT_W'(LOCK_CNT)) ? count_reg : count_reg + 1'b1;
                            locked_next = (count_next == CNT_W'(LOCK_CNT));
                        end else begin
                            count_next  = '0;
                            locked_next = 1'b0;
                        end
                    end
                end
                default: begin
                    if (!enable) increment_next = INC_W'(INC_START);
                end
            endcase
        end
    end

    // Output and counter registers
    always_ff @(posedge clk12d5MHz) begin
        if (rst) begin
            increment_reg <= INC_W'(INC_START);
            count_reg     <= '0;
            locked_reg    <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            increment_reg <= increment_next;
            count_reg     <= count_next;
            locked_reg    <= locked_next;
            fault_reg     <= (state_next == ST_FAULT);
        end
    end

    assign increment = increment_reg;
    assign locked    = locked_reg;
    assign fault     = fault_reg;
    assign state_o   = state_reg;

endmodule

// File: tb/tb_piezo_phase_lock_ctrl.sv
// Self-checking bench for piezo_phase_lock_ctrl: directed scenarios plus
// randomized traffic, all compared against a behavioural reference model.
module tb_piezo_phase_lock_ctrl;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic signed [8:0] phase;
    logic              phase_vld;
    logic              short_fault;
    logic [14:0]       increment;
    logic              locked;
    logic              fault;
    logic [1:0]        state_o;

    always #5 clk = ~clk;

    piezo_phase_lock_ctrl dut (
        .clk12d5MHz  (clk),
        .rst         (rst),
        .enable      (enable),
        .phase       (phase),
        .phase_vld   (phase_vld),
        .short_fault (short_fault),
        .increment   (increment),
        .locked      (locked),
        .fault       (fault),
        .state_o     (state_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 sweep, 2 track, 3 fault
    int m_state;
    int m_inc;
    int m_cnt;
    int m_locked;
    int m_hist[$];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q--;
        return q;
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic model_step(input bit r, input bit en, input int ph, input bit vld, input bit sf);
        int e;
        int s;
        if (r) begin
            m_state = 0; m_inc = 27500; m_cnt = 0; m_locked = 0;
            m_hist.delete();
        end else if (sf) begin
            m_state = 3; m_cnt = 0; m_locked = 0;
        end else begin
            case (m_state)
                0: begin
                    m_inc = 27500; m_cnt = 0; m_locked = 0;
                    if (en) m_state = 1;
                end
                1: begin
                    if (!en) begin
                        m_state = 0; m_inc = 27500;
                    end else if (vld) begin
                        if (ph >= 0) begin
                            m_state = 2;
                            m_hist = '{ph, ph, ph, ph};
                        end else if (m_inc - 4 < 25000) begin
                            m_state = 3;
                        end else begin
                            m_inc = m_inc - 4;
                        end
                    end
                end
                2: begin
                    if (!en) begin
                        m_state = 0; m_inc = 27500; m_cnt = 0; m_locked = 0;
                    end else if (vld) begin
`ifdef PIEZO_PLC_AVG_EN
                        void'(m_hist.pop_front());
                        m_hist.push_back(ph);
                        s = 0;
                        foreach (m_hist[k]) s += m_hist[k];
                        e = floor_div(s, 4);
`else
                        s = 0;
                        e = ph;
`endif
                        m_inc = m_inc + floor_div(e, 8);
                        if (m_inc > 28500) m_inc = 28500;
                        if (m_inc < 25000) m_inc = 25000;
                        if (iabs(e) <= 8) begin
                            if (m_cnt < 16) m_cnt++;
                            m_locked = (m_cnt == 16);
                        end else begin
                            m_cnt = 0; m_locked = 0;
                        end
                    end
                end
                default: begin
                    if (!en) begin
                        m_state = 0; m_inc = 27500;
                    end
                end
            endcase
        end
    endtask

    // One clock of stimulus, model update and full output comparison
    task automatic cyc(input string tag, input bit r, input bit en, input int ph, input bit vld, input bit sf);
        rst = r; enable = en; phase = 9'(ph); phase_vld = vld; short_fault = sf;
        @(posedge clk);
        model_step(r, en, ph, vld, sf);
        #1;
        check({tag, ".inc"},    int'(increment), m_inc);
        check({tag, ".locked"}, int'(locked),    m_locked);
        check({tag, ".fault"},  int'(fault),     (m_state == 3) ? 1 : 0);
        check({tag, ".state"},  int'(state_o),   m_state);
        if (vld || r || sf)
            $display("%s r=%0d en=%0d ph=%0d vld=%0d sf=%0d -> inc=%0d locked=%0d state=%0d",
                     tag, r, en, ph, vld, sf, increment, locked, state_o);
    endtask

    task automatic strobe(input string tag, input int ph);
        cyc(tag, 0, 1, ph, 1, 0);
        cyc(tag, 0, 1, 0, 0, 0);
    endtask

    initial begin
        int n;
        rst = 1; enable = 0; phase = '0; phase_vld = 0; short_fault = 0;
        m_state = 0; m_inc = 27500; m_cnt = 0; m_locked = 0;

        // Reset state
        cyc("rst", 1, 0, 0, 0, 0);
        cyc("rst", 1, 1, -40, 1, 0);
        check("rst_inc", int'(increment), 27500);
        check("rst_state", int'(state_o), 0);

        // 1: enter sweep, three negative strobes
        cyc("t1_en", 0, 1, 0, 0, 0);
        check("t1_sweep", int'(state_o), 1);
        strobe("t1", -40);
        check("t1_inc1", int'(increment), 27496);
        strobe("t1", -40);
        strobe("t1", -40);
        check("t1_inc3", int'(increment), 27488);

        // 2: resonance found, then proportional step
        cyc("t2", 0, 1, 5, 1, 0);
        check("t2_track", int'(state_o), 2);
        check("t2_hold", int'(increment), 27488);
        cyc("t2", 0, 1, 0, 0, 0);
        strobe("t2", 40);
        check("t2_step", int'(increment), 27493);

        // 3: lock after 16 in-tolerance samples, lost on a large one
        for (int i = 0; i < 16; i++) begin
            cyc("t3", 0, 1, 3, 1, 0);
            if (i == 14) check("t3_not_yet", int'(locked), 0);
            cyc("t3", 0, 1, 0, 0, 0);
        end
        check("t3_locked", int'(locked), 1);
        strobe("t3", 20);
        check("t3_unlock", int'(locked), 0);

        // 4: clamps at both ends
        n = 0;
        while (m_inc < 28498 && n < 2000) begin
            strobe("t4up", (28498 - m_inc >= 10) ? 80 : 8);
            n++;
        end
        check("t4_at_28498", int'(increment), 28498);
        strobe("t4hi", 80);
        check("t4_clamp_hi", int'(increment), 28500);
        n = 0;
        while (m_inc > 25001 && n < 2000) begin
            strobe("t4dn", (m_inc - 25001 >= 10) ? -80 : -8);
            n++;
        end
        check("t4_at_25001", int'(increment), 25001);
        strobe("t4lo", -80);
        check("t4_clamp_lo", int'(increment), 25000);

        // 6: short with simultaneous strobe, release sequencing
        cyc("t6", 0, 1, 80, 1, 1);
        check("t6_fault", int'(fault), 1);
        check("t6_hold", int'(increment), 25000);
        cyc("t6", 0, 1, 0, 0, 0);
        cyc("t6", 0, 1, 0, 0, 0);
        check("t6_stay", int'(state_o), 3);
        cyc("t6", 0, 0, 0, 0, 0);
        check("t6_idle", int'(state_o), 0);
        check("t6_inc", int'(increment), 27500);

        // 5: sweep never finds resonance
        cyc("t5_en", 0, 1, 0, 0, 0);
        n = 0;
        while (fault !== 1'b1 && n < 1000) begin
            cyc("t5", 0, 1, -1, 1, 0);
            n++;
        end
        check("t5_strobes", n, 626);
        check("t5_inc", int'(increment), 25000);
        cyc("t5_exit", 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int ph;
            int mode;
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: ph = int'($urandom_range(0, 24)) - 12;
                1: ph = int'($urandom_range(0, 511)) - 256;
                2: ph = int'($urandom_range(0, 80)) - 40;
                default: ph = int'($urandom_range(0, 6)) - 3;
            endcase
            cyc("rnd", ($urandom_range(0, 499) == 0), ($urandom_range(0, 59) != 0), ph,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
